ydm_responder: RTL and testbench
================================

Name: ydm_responder

Overview:
- Memory-side responder for the data-memory request interface driven by yDM (mem_read/mem_write, address, write data).
- Replaces the zero-latency mem model with a multi-cycle word-addressed RAM.
- Provides a busy/done handshake so a multicycle or stalled datapath can wait for load and store completion.
- Sits between the yDM stage and the data storage.

Parameters:
- DEPTH, 1024: number of 32-bit words; must be a power of two, at least 2.
- LATENCY, 2: clock edges from request capture to done; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- mem_read  input  1  load request; held by the initiator until done
- mem_write  input  1  store request; held by the initiator until done
- addr  input  32  byte address
- wdata  input  32  store data
- rdata  output  32  load data; valid while done=1, held until the next load completes
- busy  output  1  transaction in progress (state != IDLE)
- done  output  1  one-cycle completion pulse
- err  output  1  misaligned access flag, valid with done

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - Asserting rst_n=0 forces state=IDLE, cnt=0, rdata=0, busy=0, done=0, err=0.
  - Captured request registers are cleared.
  - RAM contents are not reset.
  - Reset mid-transaction discards a pending store; the array is not written.
- State IDLE:
  - On a rising edge with mem_read|mem_write=1, capture addr, wdata and op; load cnt=LATENCY-1; go to WAIT.
  - If both mem_read and mem_write are 1, the write takes priority, the read is ignored and rdata is unchanged.
- State WAIT:
  - Each edge with cnt!=0 decrements cnt.
  - At the edge with cnt==0, perform the access and go to DONE.
  - Store: array[idx] <= captured wdata.
  - Load: rdata <= array[idx].
- State DONE:
  - done=1 for exactly one cycle; next edge returns to IDLE.
  - Requests present during DONE are not captured.
  - A request still high in the following IDLE cycle starts a new transaction, so the initiator must drop its request on the edge after it sees done.
- Latency: done is high during the cycle after the LATENCY-th edge following capture. Example with LATENCY=2: capture E0, done high between E2 and E3. busy is high from E0 until the E3 edge.
- Inputs during WAIT and DONE are ignored; only captured values are used.
- Address index: idx = captured addr[$clog2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4.
- Back-to-back: store then load to the same address returns the stored value (no forwarding needed, since the accesses are serialized).

Optional Feature:
- YDM_MISALIGN_TRAP_EN defined:
  - A captured addr[1:0]!=0 suppresses the array access: no write, and rdata is unchanged.
  - err=1 for the done cycle; timing is otherwise identical.
- YDM_MISALIGN_TRAP_EN undefined:
  - addr[1:0] is ignored and the access proceeds on the word index.
  - err is tied to 0.

Decomposition:
- Shared package ydm_pkg holds:
  - State encoding localparams ST_IDLE=2'd0, ST_WAIT=2'd1, ST_DONE=2'd2.
  - Op encoding OP_RD=1'b0, OP_WR=1'b1.
- Sub-module ydm_array: DEPTH x 32 storage with synchronous write enable and synchronous read into a registered output. The responder FSM instantiates it once.

Test Plan:
- Reset, then idle: rst_n low 3 cycles, release → rdata=0, busy=0, done=0, err=0; no done pulse for 10 idle cycles.
- Store/load (LATENCY=2):
  - Store 32'hCAFEF00D at addr 32'h40 → busy high 3 cycles, done on the 3rd.
  - Then load 32'h40 → rdata=32'hCAFEF00D with done.
- Wrap (DEPTH=1024): store 32'h11111111 at 32'h0, then load 32'h1000 → rdata=32'h11111111.
- Simultaneous read and write at 32'h8 with wdata 32'h5A5A5A5A:
  - Treated as a write; rdata is unchanged.
  - A subsequent load of 32'h8 returns 32'h5A5A5A5A.
- Reset mid-store:
  - Store 32'hFFFFFFFF at 32'h20 (previously 32'h1); assert rst_n during WAIT.
  - After reset, busy=0, and a load of 32'h20 returns 32'h1.
- Misalignment:
  - YDM_MISALIGN_TRAP_EN defined: store at 32'h22 → err=1 with done; array unchanged.
  - Undefined: store lands at word 8 and err=0.

Source files
------------

// File: rtl/ydm_pkg.sv
// ydm_pkg: state and op encodings shared by the yDM memory responder.
package ydm_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/ydm_array.sv
// ydm_array: DEPTH x 32 word storage, synchronous write, registered synchronous read.
module ydm_array #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  // Storage is intentionally never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[idx_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/ydm_responder.sv
// ydm_responder: multi-cycle word RAM responder with busy/done handshake for yDM.
// Optional YDM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged on err.
module ydm_responder
  import ydm_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          op_q;
  logic          req, start, fire, mis, access;
  assign req   = mem_read | mem_write;
  assign start = (state_q == ST_IDLE) & req;
  assign fire  = (state_q == ST_WAIT) & (cnt_q == '0);
  always_comb begin
    state_d = start ? ST_WAIT :
              fire ? ST_DONE :
              (state_q == ST_DONE) ? ST_IDLE : state_q;
    cnt_d   = start ? CW'(LATENCY - 1) :
              ((state_q == ST_WAIT) && (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_RD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        addr_q  <= addr[AW+1:0];
        wdata_q <= wdata;
        op_q    <= mem_write ? OP_WR : OP_RD;
      end
    end
  end
`ifdef YDM_MISALIGN_TRAP_EN
  assign mis = addr_q[1:0] != 2'b00;
`else
  assign mis = 1'b0;
`endif
  assign access = fire & ~mis;
  ydm_array #(.DEPTH(DEPTH)) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (access & (op_q == OP_WR)),
    .re_i   (access & (op_q == OP_RD)),
    .idx_i  (addr_q[AW+1:2]),
    .wdata_i(wdata_q),
    .rdata_o(rdata)
  );
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_DONE;
  assign err  = done & mis;
endmodule

// File: tb/tb_ydm_responder.sv
// tb_ydm_responder: randomized scoreboard bench for ydm_responder against a word-array model.
module tb_ydm_responder;
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, err;

  ydm_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rdata = '0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: serialized word memory, write wins over read, misaligned trapped when enabled.
  task automatic model(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int  idx;
    logic mis;
    idx = int'(a % (DEPTH * 4)) / 4;
`ifdef YDM_MISALIGN_TRAP_EN
    mis = (a % 4) != 0;
`else
    mis = 1'b0;
`endif
    if (wr) begin
      if (!mis) model_mem[idx] = d;
    end else if (rd && !mis) begin
      model_rdata = model_mem[idx];
    end
    sb.push_back('{rdata: model_rdata, err: mis});
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending transaction");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rdata", rdata, e.rdata);
        chk("err", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    model(rd, wr, a, d);
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) chk("busy_after_capture", {31'd0, busy}, 32'd1);
    end while (!done && n < 20);
    chk("latency", n, LATENCY + 1);
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(done) + int'(busy);
    end
    chk("idle_quiet", pulses, 0);

    for (int i = 0; i < 16; i++) txn(1'b0, 1'b1, 32'(i * 4), $urandom);

    txn(1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
    txn(1'b1, 1'b0, 32'h40, 32'h0);
    txn(1'b0, 1'b1, 32'h0, 32'h11111111);
    txn(1'b1, 1'b0, 32'h1000, 32'h0);
    txn(1'b1, 1'b1, 32'h8, 32'h5A5A5A5A);
    txn(1'b1, 1'b0, 32'h8, 32'h0);

    txn(1'b0, 1'b1, 32'h20, 32'h1);
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h20; wdata = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_rdata", rdata, 32'd0);
    rst_n = 1'b1;
    model_rdata = '0;
    txn(1'b1, 1'b0, 32'h20, 32'h0);

    txn(1'b0, 1'b1, 32'h22, 32'hDEADBEEF);
    txn(1'b1, 1'b0, 32'h20, 32'h0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [1:0]  k;
      a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      k = 2'($urandom_range(0, 3));
      txn(k != 2'd2, k[1], a, $urandom);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
